// File: rtl/reg_file_32x32.sv
// 32-entry two-read/one-write register file with registered read ports,
// write-to-read bypass and a hard-wired zero entry.
module reg_file_32x32 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] Reg_rs1,
  output logic [DATA_W-1:0] Reg_rs2,
  output logic              rvalid
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [Depth];
  logic [DATA_W-1:0] r_rs1;
  logic [DATA_W-1:0] r_rs2;
  logic              r_rvalid;

  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  // Writes to index 0 are dropped entirely, so entry 0 stays zero forever.
  assign w_wr_en = we && (rd != '0);

  always_comb begin
    w_rd1 = r_mem[rs1];
    if (rs1 == '0) begin
      w_rd1 = '0;
    end else if (w_wr_en && (rd == rs1)) begin
      w_rd1 = wd;
    end
  end

  always_comb begin
    w_rd2 = r_mem[rs2];
    if (rs2 == '0) begin
      w_rd2 = '0;
    end else if (w_wr_en && (rd == rs2)) begin
      w_rd2 = wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[rd] <= wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= en;
      if (en) begin
        r_rs1 <= w_rd1;
        r_rs2 <= w_rd2;
      end
    end
  end

  assign Reg_rs1 = r_rs1;
  assign Reg_rs2 = r_rs2;
  assign rvalid  = r_rvalid;

endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed vector bench for reg_file_32x32: table of single-edge vectors plus
// hand-written reset and fill/readback sequences.
module tb_reg_file_32x32;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [31:0] Reg_rs1;
  logic [31:0] Reg_rs2;
  logic        rvalid;

  int total;
  int bad;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        en;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ev;
  } vec_t;

  vec_t vecs[13];

  reg_file_32x32 #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rs1    (rs1),
    .rs2    (rs2),
    .we     (we),
    .rd     (rd),
    .wd     (wd),
    .Reg_rs1(Reg_rs1),
    .Reg_rs2(Reg_rs2),
    .rvalid (rvalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic w, logic [4:0] a, logic [31:0] d, logic e,
                              logic [4:0] r1, logic [4:0] r2,
                              logic [31:0] x1, logic [31:0] x2, logic xv);
    vec_t v;
    v.we = w; v.rd = a; v.wd = d; v.en = e; v.rs1 = r1; v.rs2 = r2;
    v.e1 = x1; v.e2 = x2; v.ev = xv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] x1, input logic [31:0] x2,
                         input logic xv);
    chk({tag, " Reg_rs1"}, Reg_rs1, x1);
    chk({tag, " Reg_rs2"}, Reg_rs2, x2);
    chk({tag, " rvalid"}, {31'd0, rvalid}, {31'd0, xv});
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic e, input logic [4:0] r1, input logic [4:0] r2);
    we = w; rd = a; wd = d; en = e; rs1 = r1; rs2 = r2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = mk(0, 5'd0, 32'h0,        1, 5'd5,  5'd31, 32'h0,        32'h0,        1);
    vecs[1]  = mk(1, 5'd3, 32'hDEADBEEF, 0, 5'd0,  5'd0,  32'h0,        32'h0,        0);
    vecs[2]  = mk(0, 5'd0, 32'h0,        1, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        1);
    vecs[3]  = mk(1, 5'd7, 32'h12345678, 1, 5'd7,  5'd7,  32'h12345678, 32'h12345678, 1);
    vecs[4]  = mk(0, 5'd0, 32'h0,        1, 5'd7,  5'd3,  32'h12345678, 32'hDEADBEEF, 1);
    vecs[5]  = mk(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0,  5'd0,  32'h0,        32'h0,        1);
    vecs[6]  = mk(0, 5'd0, 32'h0,        1, 5'd0,  5'd7,  32'h0,        32'h12345678, 1);
    vecs[7]  = mk(1, 5'd3, 32'h11112222, 1, 5'd3,  5'd3,  32'h11112222, 32'h11112222, 1);
    vecs[8]  = mk(1, 5'd9, 32'hA5A5A5A5, 1, 5'd9,  5'd3,  32'hA5A5A5A5, 32'h11112222, 1);
    vecs[9]  = mk(1, 5'd4, 32'h00000055, 1, 5'd9,  5'd4,  32'hA5A5A5A5, 32'h00000055, 1);
    vecs[10] = mk(0, 5'd0, 32'h0,        0, 5'd1,  5'd2,  32'hA5A5A5A5, 32'h00000055, 0);
    vecs[11] = mk(1, 5'd9, 32'h0BADF00D, 0, 5'd9,  5'd9,  32'hA5A5A5A5, 32'h00000055, 0);
    vecs[12] = mk(0, 5'd0, 32'h0,        0, 5'd9,  5'd4,  32'hA5A5A5A5, 32'h00000055, 0);

    rst_n = 1'b0;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);
    #1;
    chk_out("reset", 32'h0, 32'h0, 0);
    tick();
    tick();
    #3;
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].en, vecs[i].rs1, vecs[i].rs2);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].ev);
    end

    // Entry 9 was rewritten with en=0 in vec11; confirm the stored value.
    drive(0, 5'd0, 32'h0, 1, 5'd9, 5'd0);
    tick();
    chk_out("rd9", 32'h0BADF00D, 32'h0, 1);

    // Asynchronous reset between edges, with a write and read attempted during it.
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 32'h0, 32'h0, 0);
    drive(1, 5'd9, 32'h77777777, 1, 5'd9, 5'd9);
    tick();
    chk_out("in_rst", 32'h0, 32'h0, 0);
    #3;
    rst_n = 1'b1;
    drive(1, 5'd5, 32'h0000CAFE, 1, 5'd9, 5'd5);
    tick();
    chk_out("first_edge", 32'h0, 32'h0000CAFE, 1);
    drive(0, 5'd0, 32'h0, 1, 5'd5, 5'd3);
    tick();
    chk_out("post_rst", 32'h0000CAFE, 32'h0, 1);

    // Fill entries 1..31 with i+1, then read mirrored pairs.
    for (int i = 1; i < 32; i++) begin
      drive(1, 5'(i), 32'(i + 1), 0, 5'd0, 5'd0);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      logic [31:0] x1;
      logic [31:0] x2;
      x1 = (i == 0) ? 32'h0 : 32'(i + 1);
      x2 = (i == 31) ? 32'h0 : 32'(32 - i);
      drive(0, 5'd0, 32'h0, 1, 5'(i), 5'(31 - i));
      tick();
      chk_out($sformatf("pair%0d", i), x1, x2, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
